// File: rtl/reaction_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_timer_pkg
//  Description : Shared types and constants for the reaction-timer datapath,
//                control FSM and display stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package reaction_timer_pkg;

    // Delay sequencer states
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RAND_WAIT  = 2'd1,
        FIXED_WAIT = 2'd2
    } dly_state_t;

    // Right-shift Galois mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] c_LFSR_TAPS         = 16'hB400;

    localparam int          c_BCD_DIGIT_W       = 4;
    localparam int          c_BCD_DIGITS        = 4;

    localparam logic [15:0] c_LATE_BCD_DEFAULT  = 16'h9999;
    localparam logic [15:0] c_LFSR_SEED_DEFAULT = 16'hACE1;

    // One LFSR step; a non-zero state can never map to zero
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? c_LFSR_TAPS : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reaction_timer_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_timer_datapath_if
//  Description : Strobe/status bundle between the reaction-timer control FSM
//                (master) and the timing datapath (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface reaction_timer_datapath_if;

    logic        start_rwait;
    logic        start_wait5;
    logic        time_clr;
    logic        time_en;
    logic        rs_en;
    logic        rwait_done;
    logic        wait5_done;
    logic        time_late;
    logic [15:0] rt_live;
    logic [15:0] rt_result;

    modport master (
        output start_rwait, start_wait5, time_clr, time_en, rs_en,
        input  rwait_done, wait5_done, time_late, rt_live, rt_result
    );

    modport slave (
        input  start_rwait, start_wait5, time_clr, time_en, rs_en,
        output rwait_done, wait5_done, time_late, rt_live, rt_result
    );

endinterface
`default_nettype wire

// File: rtl/reaction_timer_datapath_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_counter4
//  Description : 4-digit BCD up-counter with synchronous clear, count enable
//                and saturation at a fixed limit (sticky flag until clear).
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_counter4
    import reaction_timer_pkg::*;
#(
    parameter logic [15:0] LIMIT = c_LATE_BCD_DEFAULT
)(
    input  wire logic        clk,
    input  wire logic        RESET,
    input  wire logic        i_clr,
    input  wire logic        i_en,
    output logic      [15:0] o_count,
    output logic             o_sat
);

    logic [15:0] r_count;
    logic        r_sat;
    logic [15:0] w_inc;
    logic        w_at_limit;

    assign w_at_limit = (r_count == LIMIT);

    // Ripple BCD increment: each digit wraps 9->0 and carries into the next
    always_comb begin
        logic                     carry;
        logic [c_BCD_DIGIT_W-1:0] digit;
        w_inc = r_count;
        carry = 1'b1;
        for (int d = 0; d < c_BCD_DIGITS; d++) begin
            digit = r_count[d*c_BCD_DIGIT_W +: c_BCD_DIGIT_W];
            if (carry) begin
                if (digit == 4'd9) begin
                    w_inc[d*c_BCD_DIGIT_W +: c_BCD_DIGIT_W] = 4'd0;
                end else begin
                    w_inc[d*c_BCD_DIGIT_W +: c_BCD_DIGIT_W] = digit + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // Count register; clear wins, and the count freezes once it hits LIMIT
    always_ff @(posedge clk) begin
        if (!RESET) begin
            r_count <= 16'h0000;
            r_sat   <= 1'b0;
        end else if (i_clr) begin
            r_count <= 16'h0000;
            r_sat   <= 1'b0;
        end else if (i_en && !w_at_limit) begin
            r_count <= w_inc;
            r_sat   <= (w_inc == LIMIT);
        end
    end

    assign o_count = r_count;
    assign o_sat   = r_sat;

endmodule
`default_nettype wire

// File: rtl/reaction_timer_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_timer_datapath
//  Description : Timing datapath for the reaction timer: ms prescaler,
//                free-running LFSR, random/fixed delay sequencer, saturating
//                BCD reaction counter and result register.
//  Revision    : 1.0 - initial release
// ============================================================================
module reaction_timer_datapath
    import reaction_timer_pkg::*;
#(
    parameter int          MS_DIV       = 100000,
    parameter int          RWAIT_MIN_MS = 2000,
    parameter int          WAIT5_MS     = 5000,
    parameter logic [15:0] LATE_BCD     = c_LATE_BCD_DEFAULT,
    parameter logic [15:0] LFSR_SEED    = c_LFSR_SEED_DEFAULT
)(
    input  wire logic                 clk,
    input  wire logic                 RESET,
    reaction_timer_datapath_if.slave  bus
);

    localparam int c_PRE_W    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam int c_RAND_MAX = RWAIT_MIN_MS + 4095;
    localparam int c_DLY_MAX  = (c_RAND_MAX > WAIT5_MS) ? c_RAND_MAX : WAIT5_MS;
    localparam int c_DLY_W    = $clog2(c_DLY_MAX + 1);

    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(MS_DIV - 1);
    localparam logic [c_DLY_W-1:0] c_DLY_ONE  = c_DLY_W'(1);

    logic [c_PRE_W-1:0] r_pre;
    logic               w_ms_tick;
    logic               w_restart;

    logic [15:0]        r_lfsr;

    dly_state_t         r_state;
    dly_state_t         w_state_nxt;
    logic [c_DLY_W-1:0] r_dly;
    logic [c_DLY_W-1:0] w_dly_nxt;
    logic [c_DLY_W-1:0] w_rand_load;
    logic               r_rwait_done;
    logic               r_wait5_done;
    logic               w_rwait_done_nxt;
    logic               w_wait5_done_nxt;

    logic [15:0]        w_rt_live;
    logic               w_time_late;
    logic [15:0]        r_rt_result;

    // Any start or clear re-phases the prescaler so intervals are whole ms
    assign w_restart = bus.start_rwait | bus.start_wait5 | bus.time_clr;
    assign w_ms_tick = (r_pre == c_PRE_LAST);

    // Millisecond prescaler
    always_ff @(posedge clk) begin
        if (!RESET) begin
            r_pre <= '0;
        end else if (w_restart || w_ms_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Free-running LFSR; player timing decides which value gets sampled
    always_ff @(posedge clk) begin
        if (!RESET) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign w_rand_load = c_DLY_W'(RWAIT_MIN_MS) + c_DLY_W'(r_lfsr[11:0]);

    // Delay sequencer state, down-counter and registered done pulses
    always_ff @(posedge clk) begin
        if (!RESET) begin
            r_state      <= IDLE;
            r_dly        <= '0;
            r_rwait_done <= 1'b0;
            r_wait5_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dly        <= w_dly_nxt;
            r_rwait_done <= w_rwait_done_nxt;
            r_wait5_done <= w_wait5_done_nxt;
        end
    end

    // Next-state: starts always reload (rwait first); ticks count down
    always_comb begin
        w_state_nxt      = r_state;
        w_dly_nxt        = r_dly;
        w_rwait_done_nxt = 1'b0;
        w_wait5_done_nxt = 1'b0;
        if (bus.start_rwait) begin
            w_dly_nxt   = w_rand_load;
            w_state_nxt = RAND_WAIT;
        end else if (bus.start_wait5) begin
            w_dly_nxt   = c_DLY_W'(WAIT5_MS);
            w_state_nxt = FIXED_WAIT;
        end else if (w_ms_tick) begin
            case (r_state)
                RAND_WAIT, FIXED_WAIT: begin
                    if (r_dly <= c_DLY_ONE) begin
                        w_dly_nxt        = '0;
                        w_state_nxt      = IDLE;
                        w_rwait_done_nxt = (r_state == RAND_WAIT);
                        w_wait5_done_nxt = (r_state == FIXED_WAIT);
                    end else begin
                        w_dly_nxt = r_dly - c_DLY_ONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    bcd_counter4 #(
        .LIMIT (LATE_BCD)
    ) u_rt_cnt (
        .clk     (clk),
        .RESET   (RESET),
        .i_clr   (bus.time_clr),
        .i_en    (bus.time_en & w_ms_tick),
        .o_count (w_rt_live),
        .o_sat   (w_time_late)
    );

    // Result capture takes the live count before any same-cycle clear
    always_ff @(posedge clk) begin
        if (!RESET) begin
            r_rt_result <= 16'h0000;
        end else if (bus.rs_en) begin
            r_rt_result <= w_rt_live;
        end
    end

    assign bus.rwait_done = r_rwait_done;
    assign bus.wait5_done = r_wait5_done;
    assign bus.time_late  = w_time_late;
    assign bus.rt_live    = w_rt_live;
    assign bus.rt_result  = r_rt_result;

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reaction_timer_datapath
//  Description : Self-checking bench for reaction_timer_datapath. Two
//                instances share stimulus: one with the default saturation
//                limit and one saturating at 0012.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_timer_datapath;

    localparam int          MS_DIV = 4;
    localparam int          RWMIN  = 2;
    localparam int          W5     = 5;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic clk = 1'b0;
    logic RESET;
    int   edge_cnt = 0;
    int   pre_ref  = 0;
    int   errors   = 0;
    int   checks   = 0;
    logic [15:0] m_lfsr;

    reaction_timer_datapath_if bus_a();
    reaction_timer_datapath_if bus_b();

    assign bus_b.start_rwait = bus_a.start_rwait;
    assign bus_b.start_wait5 = bus_a.start_wait5;
    assign bus_b.time_clr    = bus_a.time_clr;
    assign bus_b.time_en     = bus_a.time_en;
    assign bus_b.rs_en       = bus_a.rs_en;

    reaction_timer_datapath #(
        .MS_DIV(MS_DIV), .RWAIT_MIN_MS(RWMIN), .WAIT5_MS(W5),
        .LATE_BCD(16'h9999), .LFSR_SEED(SEED)
    ) dut_a (.clk(clk), .RESET(RESET), .bus(bus_a.slave));

    reaction_timer_datapath #(
        .MS_DIV(MS_DIV), .RWAIT_MIN_MS(RWMIN), .WAIT5_MS(W5),
        .LATE_BCD(16'h0012), .LFSR_SEED(SEED)
    ) dut_b (.clk(clk), .RESET(RESET), .bus(bus_b.slave));

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    // Polynomial x^16+x^14+x^13+x^11+1, shifting right: exponents 16,14,13,11
    // feed back into bit positions 15,13,12,10.
    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] v;
        v = s >> 1;
        if (s[0]) begin
            v[15] = ~v[15];
            v[13] = ~v[13];
            v[12] = ~v[12];
            v[10] = ~v[10];
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (!RESET) m_lfsr <= SEED;
        else        m_lfsr <= model_step(m_lfsr);
    end

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Pulse strobes for one cycle; returns the sampling edge and the LFSR
    // value that edge sees. Called and returns at a falling edge.
    task automatic strobe(input bit rw, input bit w5, input bit clr,
                          output int e, output logic [15:0] lv);
        bus_a.start_rwait = rw;
        bus_a.start_wait5 = w5;
        bus_a.time_clr    = clr;
        lv = m_lfsr;
        @(negedge clk);
        e = edge_cnt;
        pre_ref = e;
        bus_a.start_rwait = 1'b0;
        bus_a.start_wait5 = 1'b0;
        bus_a.time_clr    = 1'b0;
    endtask

    // Hold time_en until n ms ticks have been sampled
    task automatic run_ticks(input int n);
        int cnt;
        cnt = 0;
        bus_a.time_en = 1'b1;
        while (cnt < n) begin
            @(negedge clk);
            if (edge_cnt > pre_ref && (edge_cnt - pre_ref) % MS_DIV == 0) cnt++;
        end
        bus_a.time_en = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        repeat (2) begin
            bus_a.start_rwait = 1'($urandom);
            bus_a.start_wait5 = 1'($urandom);
            bus_a.time_clr    = 1'($urandom);
            bus_a.time_en     = 1'($urandom);
            bus_a.rs_en       = 1'($urandom);
            @(negedge clk);
        end
        checks++; if (bus_a.rwait_done !== 1'b0) begin errors++; $display("FAIL reset_rwait_done got=%b exp=0", bus_a.rwait_done); end
        checks++; if (bus_a.wait5_done !== 1'b0) begin errors++; $display("FAIL reset_wait5_done got=%b exp=0", bus_a.wait5_done); end
        checks++; if (bus_a.time_late !== 1'b0) begin errors++; $display("FAIL reset_time_late got=%b exp=0", bus_a.time_late); end
        checks++; if (bus_a.rt_live !== 16'h0000) begin errors++; $display("FAIL reset_rt_live got=%h exp=0000", bus_a.rt_live); end
        checks++; if (bus_a.rt_result !== 16'h0000) begin errors++; $display("FAIL reset_rt_result got=%h exp=0000", bus_a.rt_result); end
        checks++; if (bus_b.rt_live !== 16'h0000 || bus_b.time_late !== 1'b0) begin errors++; $display("FAIL reset_b got=%h/%b exp=0000/0", bus_b.rt_live, bus_b.time_late); end
        bus_a.start_rwait = 1'b0;
        bus_a.start_wait5 = 1'b0;
        bus_a.time_clr    = 1'b0;
        bus_a.time_en     = 1'b0;
        bus_a.rs_en       = 1'b0;
        RESET = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus_a.rt_result !== 16'h0000) begin errors++; $display("FAIL post_reset_rt_result got=%h exp=0000", bus_a.rt_result); end
    endtask

    task automatic test_fixed_wait;
        int e0;
        logic [15:0] lv;
        repeat ($urandom_range(0, 5)) @(negedge clk);
        strobe(1'b0, 1'b1, 1'b0, e0, lv);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if (bus_a.wait5_done !== (edge_cnt == e0 + W5 * MS_DIV)) begin
                errors++;
                $display("FAIL fixed_wait5_done at edge+%0d got=%b exp=%b", edge_cnt - e0, bus_a.wait5_done, (edge_cnt == e0 + W5 * MS_DIV));
            end
            checks++;
            if (bus_a.rwait_done !== 1'b0) begin errors++; $display("FAIL fixed_rwait_done at edge+%0d got=1 exp=0", edge_cnt - e0); end
        end
    endtask

    task automatic test_random_wait;
        int e0, e1, n0, n1, got, iv[2], nn[2], end_edge, got5;
        logic [15:0] lv;
        bit saw_rw;
        for (int r = 0; r < 2; r++) begin
            repeat (r == 0 ? $urandom_range(0, 9) : 7) @(negedge clk);
            strobe(1'b1, 1'b0, 1'b0, e0, lv);
            n0 = RWMIN + int'(lv[11:0]);
            nn[r] = n0;
            got = -1;
            while (got < 0 && edge_cnt < e0 + 16400) begin
                @(negedge clk);
                if (bus_a.rwait_done === 1'b1) got = edge_cnt;
            end
            iv[r] = got - e0;
            checks++;
            if (got !== e0 + n0 * MS_DIV) begin errors++; $display("FAIL rand_done_edge run%0d got=+%0d exp=+%0d", r, got - e0, n0 * MS_DIV); end
            checks++;
            if (got < 0 || iv[r] < 8 || iv[r] > 16388) begin errors++; $display("FAIL rand_interval_range run%0d got=%0d exp=8..16388", r, iv[r]); end
        end
        if (nn[0] != nn[1]) begin
            checks++;
            if (iv[0] == iv[1]) begin errors++; $display("FAIL rand_intervals_differ got=%0d/%0d exp=different", iv[0], iv[1]); end
        end
        // Abort a random wait halfway with a fixed wait
        strobe(1'b1, 1'b0, 1'b0, e0, lv);
        n0 = RWMIN + int'(lv[11:0]);
        repeat (2 * n0) @(negedge clk);
        strobe(1'b0, 1'b1, 1'b0, e1, lv);
        n1 = e1 + W5 * MS_DIV;
        end_edge = imax(e0 + n0 * MS_DIV, n1) + 4;
        saw_rw = 1'b0;
        got5 = -1;
        while (edge_cnt < end_edge) begin
            @(negedge clk);
            if (bus_a.rwait_done === 1'b1) saw_rw = 1'b1;
            if (bus_a.wait5_done === 1'b1 && got5 < 0) got5 = edge_cnt;
        end
        checks++;
        if (saw_rw !== 1'b0) begin errors++; $display("FAIL abort_rwait_done got=1 exp=0"); end
        checks++;
        if (got5 !== n1) begin errors++; $display("FAIL abort_wait5_edge got=%0d exp=%0d", got5, n1); end
    endtask

    task automatic test_reaction_count;
        int e;
        logic [15:0] lv;
        strobe(1'b0, 1'b0, 1'b1, e, lv);
        checks++; if (bus_a.rt_live !== 16'h0000) begin errors++; $display("FAIL count_clear got=%h exp=0000", bus_a.rt_live); end
        run_ticks(37);
        checks++; if (bus_a.rt_live !== to_bcd(37)) begin errors++; $display("FAIL count_37_live got=%h exp=%h", bus_a.rt_live, to_bcd(37)); end
        bus_a.rs_en = 1'b1;
        @(negedge clk);
        bus_a.rs_en = 1'b0;
        checks++; if (bus_a.rt_result !== 16'h0037) begin errors++; $display("FAIL count_37_result got=%h exp=0037", bus_a.rt_result); end
        checks++; if (bus_a.rt_live !== 16'h0037) begin errors++; $display("FAIL count_37_hold got=%h exp=0037", bus_a.rt_live); end
        run_ticks(63);
        checks++; if (bus_a.rt_live !== to_bcd(100)) begin errors++; $display("FAIL count_100_carry got=%h exp=%h", bus_a.rt_live, to_bcd(100)); end
        checks++; if (bus_a.time_late !== 1'b0) begin errors++; $display("FAIL count_no_late got=%b exp=0", bus_a.time_late); end
    endtask

    task automatic test_late;
        int e;
        logic [15:0] lv;
        strobe(1'b0, 1'b0, 1'b1, e, lv);
        for (int k = 1; k <= 20; k++) begin
            run_ticks(1);
            checks++;
            if (bus_b.rt_live !== to_bcd(k < 12 ? k : 12) || bus_b.time_late !== (k >= 12)) begin
                errors++;
                $display("FAIL late_tick%0d got=%h/%b exp=%h/%b", k, bus_b.rt_live, bus_b.time_late, to_bcd(k < 12 ? k : 12), (k >= 12));
            end
            checks++;
            if (bus_a.rt_live !== to_bcd(k)) begin errors++; $display("FAIL late_ref_tick%0d got=%h exp=%h", k, bus_a.rt_live, to_bcd(k)); end
        end
        bus_a.rs_en = 1'b1;
        @(negedge clk);
        bus_a.rs_en = 1'b0;
        checks++; if (bus_b.rt_result !== 16'h0012) begin errors++; $display("FAIL late_result got=%h exp=0012", bus_b.rt_result); end
        strobe(1'b0, 1'b0, 1'b1, e, lv);
        checks++;
        if (bus_b.time_late !== 1'b0 || bus_b.rt_live !== 16'h0000) begin
            errors++;
            $display("FAIL late_clear got=%h/%b exp=0000/0", bus_b.rt_live, bus_b.time_late);
        end
    endtask

    task automatic test_simultaneous;
        int e0, k, n0, got, got5;
        logic [15:0] lv;
        // clear and enable together
        run_ticks($urandom_range(1, 9));
        bus_a.time_clr = 1'b1;
        bus_a.time_en  = 1'b1;
        repeat (10) @(negedge clk);
        pre_ref = edge_cnt;
        bus_a.time_clr = 1'b0;
        bus_a.time_en  = 1'b0;
        checks++; if (bus_a.rt_live !== 16'h0000) begin errors++; $display("FAIL clr_en_live got=%h exp=0000", bus_a.rt_live); end
        // result capture and clear together keep the pre-clear count
        k = $urandom_range(1, 9);
        run_ticks(k);
        bus_a.rs_en    = 1'b1;
        bus_a.time_clr = 1'b1;
        @(negedge clk);
        pre_ref = edge_cnt;
        bus_a.rs_en    = 1'b0;
        bus_a.time_clr = 1'b0;
        checks++; if (bus_a.rt_result !== to_bcd(k)) begin errors++; $display("FAIL rs_clr_result got=%h exp=%h", bus_a.rt_result, to_bcd(k)); end
        checks++; if (bus_a.rt_live !== 16'h0000) begin errors++; $display("FAIL rs_clr_live got=%h exp=0000", bus_a.rt_live); end
        // both start strobes: random wait wins
        strobe(1'b1, 1'b1, 1'b0, e0, lv);
        n0 = RWMIN + int'(lv[11:0]);
        got = -1;
        got5 = -1;
        while (edge_cnt < e0 + n0 * MS_DIV + 4) begin
            @(negedge clk);
            if (bus_a.rwait_done === 1'b1 && got < 0) got = edge_cnt;
            if (bus_a.wait5_done === 1'b1 && got5 < 0) got5 = edge_cnt;
        end
        checks++; if (got !== e0 + n0 * MS_DIV) begin errors++; $display("FAIL both_start_rwait got=+%0d exp=+%0d", got - e0, n0 * MS_DIV); end
        checks++; if (got5 !== -1) begin errors++; $display("FAIL both_start_wait5 got=+%0d exp=none", got5 - e0); end
        // reset one cycle before expiry
        strobe(1'b0, 1'b1, 1'b0, e0, lv);
        while (edge_cnt < e0 + W5 * MS_DIV - 1) @(negedge clk);
        RESET = 1'b0;
        @(negedge clk);
        RESET = 1'b1;
        checks++; if (bus_a.rt_result !== 16'h0000) begin errors++; $display("FAIL reset_mid_result got=%h exp=0000", bus_a.rt_result); end
        got5 = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((bus_a.wait5_done === 1'b1 || bus_a.rwait_done === 1'b1) && got5 < 0) got5 = i;
        end
        checks++; if (got5 !== -1) begin errors++; $display("FAIL reset_mid_done got=cycle%0d exp=none", got5); end
    endtask

    initial begin
        RESET             = 1'b0;
        bus_a.start_rwait = 1'b0;
        bus_a.start_wait5 = 1'b0;
        bus_a.time_clr    = 1'b0;
        bus_a.time_en     = 1'b0;
        bus_a.rs_en       = 1'b0;
        test_reset();
        test_fixed_wait();
        test_random_wait();
        test_reaction_count();
        test_late();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reaction_timer_datapath.md
Name: reaction_timer_datapath

Overview:
Timing datapath paired with the reaction-timer control FSM. It consumes the FSM's start_rwait, start_wait5, time_clr, time_en and rs_en strobes. It produces the rwait_done, wait5_done and time_late status flags, plus a 4-digit BCD millisecond reaction result for the display stage. It contains a ms prescaler, a free-running LFSR for the random pre-stimulus delay, a delay down-counter and a saturating BCD reaction counter.

Parameters:
MS_DIV, 100000, clk cycles per millisecond tick (100 MHz clk); benches override with small values.
RWAIT_MIN_MS, 2000, minimum random delay in ms.
WAIT5_MS, 5000, fixed result-display delay in ms.
LATE_BCD, 16'h9999, BCD count at which the reaction counter saturates and time_late asserts.
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
clk  in  1  system clock, all logic on rising edge
RESET  in  1  synchronous, active-low reset (RESET=0 resets on the next clk edge)
start_rwait  in  1  from FSM: load the random delay and start it
start_wait5  in  1  from FSM: load the fixed WAIT5_MS delay and start it
time_clr  in  1  from FSM: clear the reaction counter and time_late
time_en  in  1  from FSM: count reaction time while high
rs_en  in  1  from FSM: store the live count into rt_result
rwait_done  out  1  one-cycle pulse when the random delay expires
wait5_done  out  1  one-cycle pulse when the fixed delay expires
time_late  out  1  level; high while the reaction counter is saturated
rt_live  out  16  live BCD reaction count, 4 digits
rt_result  out  16  stored BCD result for the display

Behaviour:
- Reset values: every output 0; prescaler 0; delay counter 0; delay state IDLE; LFSR = LFSR_SEED.
- Prescaler:
  - Counts 0..MS_DIV-1 and issues a one-cycle ms_tick when it equals MS_DIV-1.
  - Forced to 0 on any start_rwait, start_wait5 or time_clr, so every interval is whole ms.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances every clk cycle regardless of other inputs, so player timing supplies the entropy.
  - Never reaches all-zero.
- Delay FSM, states IDLE / RAND_WAIT / FIXED_WAIT:
  - start_rwait: load dly = RWAIT_MIN_MS + lfsr[11:0], giving 2000..6095 ms; go to RAND_WAIT.
  - start_wait5: load dly = WAIT5_MS; go to FIXED_WAIT.
  - Both strobes in the same cycle: start_rwait wins.
  - A start strobe in any state, including a busy one, aborts the current wait and reloads. The aborted wait produces no done pulse.
  - In RAND_WAIT or FIXED_WAIT, each ms_tick decrements dly. On the tick that takes dly 1->0, the matching done pulses for exactly one cycle on the next edge, and the state returns to IDLE.
  - Latency: with the start strobe sampled at edge E0, done is high for the cycle after edge E0 + N*MS_DIV, where N is the delay in ms.
  - Start strobes held high re-arm every cycle, so no done pulse occurs while they are held.
- Reaction counter (BCD, 4 digits):
  - time_clr has priority over time_en: rt_live <= 0 and time_late <= 0.
  - Otherwise, time_en & ms_tick increments in BCD. Each digit wraps 9->0 with carry.
  - When rt_live equals LATE_BCD the counter holds and time_late goes high in the same cycle. Both remain until time_clr or reset.
  - time_en low: rt_live holds.
- Result register: rs_en loads rt_result <= rt_live on the edge, which captures 9999 when late. rs_en and time_clr in the same cycle store the pre-clear value.
- Reset mid-operation: aborts everything and returns to the reset values. No done pulse follows.

Decomposition:
- Package reaction_timer_pkg holds:
  - the delay-state enum (IDLE, RAND_WAIT, FIXED_WAIT);
  - the LFSR tap mask;
  - the BCD digit width;
  - the LATE_BCD and LFSR_SEED defaults, shared with the FSM and display stages.
- One sub-module, bcd_counter4: a 4-digit BCD counter with clear, enable and saturate-at-limit. It is instantiated once.

Test Plan:
- Reset: hold RESET=0 for 2 edges with all inputs random -> all outputs 0; release, and rt_result stays 16'h0000.
- Fixed wait: MS_DIV=4, WAIT5_MS=5, one-cycle start_wait5 at E0 -> wait5_done high only in the cycle after E0+20. rwait_done stays 0.
- Random wait: MS_DIV=4, RWAIT_MIN_MS=2, two start_rwait issued 7 cycles apart in separate runs -> each done interval is in [8, 16388] cycles and the two intervals differ. A start_wait5 at mid-wait aborts the first, with no rwait_done.
- Reaction count: time_clr, then time_en high for 37 ms ticks, then rs_en -> rt_live=16'h0037 and rt_result=16'h0037. Extending the count by 63 more ticks gives 16'h0100, checking the carry.
- Late: LATE_BCD=16'h0012, time_en held 20 ms -> rt_live freezes at 16'h0012 and time_late=1 from that cycle. time_clr then gives time_late=0 and rt_live=0.
- Simultaneous events:
  - time_clr and time_en together -> rt_live=0.
  - start_rwait and start_wait5 together -> RAND_WAIT.
  - RESET=0 one cycle before expiry -> no done pulse.
